// File: rtl/instruction_fetch.sv
// Instruction fetch stage: an internal instruction memory, the PC, the IF/ID
// latch, a retired-fetch counter and a sticky halt flag. A debug port loads
// the memory while the pipeline is frozen.
module instruction_fetch #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inPC_write,
    input  logic                          inIF_ID_write,
    input  logic                          inPC_sel,
    input  logic [31:0]                   inPC_branch,
    input  logic                          inFlush,
    input  logic                          Debug_on,
    input  logic                          Debug_load_we,
    input  logic [$clog2(MEM_WORDS)-1:0]  Debug_load_addr,
    input  logic [31:0]                   Debug_load_data,
    output logic [31:0]                   outInstruction,
    output logic [31:0]                   outInstructionAddress,
    output logic [31:0]                   outPC,
    output logic                          outHalt,
    output logic [31:0]                   outInstrCount
);

    localparam int unsigned ADDR_W = $clog2(MEM_WORDS);

    logic [31:0]       r_mem [MEM_WORDS];
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic [31:0]       r_instr_addr;
    logic [31:0]       r_count;
    logic              r_halt;

    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_fetch;
    logic [31:0]       w_pc_plus4;
    logic              w_run;
    logic              w_is_halt;
    logic              w_latch;
    logic              w_halt_now;
    logic [31:0]       w_pc_next;
    logic [31:0]       w_instr_next;
    logic [31:0]       w_instr_addr_next;
    logic [31:0]       w_count_next;

    // Memory load port; contents survive reset, but a reset cycle blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && Debug_on && Debug_load_we) begin
            r_mem[Debug_load_addr] <= Debug_load_data;
        end
    end

    // Fetch decode and next-state selection; everything defaults to hold.
    always_comb begin
        w_idx             = r_pc[ADDR_W+1:2];
        w_fetch           = r_mem[w_idx];
        w_pc_plus4        = r_pc + 32'd4;
        w_run             = !Debug_on && !r_halt;
        w_is_halt         = (w_fetch == HALT_WORD);
        w_latch           = inIF_ID_write && !inFlush;
        w_halt_now        = w_latch && w_is_halt;

        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_instr_addr_next = r_instr_addr;
        w_count_next      = r_count;

        // A halting fetch freezes the PC even if a branch is taken.
        if (!w_halt_now) begin
            if (inPC_sel) begin
                w_pc_next = inPC_branch;
            end else if (inPC_write) begin
                w_pc_next = w_pc_plus4;
            end
        end

        // Flush wins over a held latch and suppresses any halt.
        if (inFlush) begin
            w_instr_next      = 32'h0;
            w_instr_addr_next = w_pc_plus4;
        end else if (inIF_ID_write) begin
            w_instr_addr_next = w_pc_plus4;
            if (w_is_halt) begin
                w_instr_next = 32'h0;
            end else begin
                w_instr_next = w_fetch;
                w_count_next = r_count + 32'd1;
            end
        end
    end

    // Pipeline state registers; only advance while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= 32'h0;
            r_instr      <= 32'h0;
            r_instr_addr <= 32'h0;
            r_count      <= 32'h0;
            r_halt       <= 1'b0;
        end else if (w_run) begin
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_instr_addr <= w_instr_addr_next;
            r_count      <= w_count_next;
            if (w_halt_now) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign outPC                 = r_pc;
    assign outInstruction        = r_instr;
    assign outInstructionAddress = r_instr_addr;
    assign outInstrCount         = r_count;
    assign outHalt               = r_halt;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// every cycle compared against a per-cycle behavioural model.
module tb_instruction_fetch;

    localparam int unsigned MW   = 16;
    localparam int unsigned AW   = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic          pc_write;
    logic          ifid_write;
    logic          pc_sel;
    logic [31:0]   pc_branch;
    logic          flush;
    logic          dbg_on;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;
    logic [31:0]   o_instr;
    logic [31:0]   o_iaddr;
    logic [31:0]   o_pc;
    logic          o_halt;
    logic [31:0]   o_count;

    // Reference model state
    logic [31:0]   m_mem [MW];
    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    logic [31:0]   m_iaddr;
    logic [31:0]   m_count;
    logic          m_halt;

    int n_cmp;
    int n_mis;

    instruction_fetch #(.MEM_WORDS(MW), .HALT_WORD(HALT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inPC_write           (pc_write),
        .inIF_ID_write        (ifid_write),
        .inPC_sel             (pc_sel),
        .inPC_branch          (pc_branch),
        .inFlush              (flush),
        .Debug_on             (dbg_on),
        .Debug_load_we        (dbg_we),
        .Debug_load_addr      (dbg_addr),
        .Debug_load_data      (dbg_data),
        .outInstruction       (o_instr),
        .outInstructionAddress(o_iaddr),
        .outPC                (o_pc),
        .outHalt              (o_halt),
        .outInstrCount        (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] prog(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the specified behaviour, evaluated with the pre-edge inputs.
    task automatic model_step();
        logic [31:0] word;
        logic        stop;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_iaddr = 0; m_count = 0; m_halt = 0;
        end else begin
            if (dbg_on && dbg_we) m_mem[dbg_addr] = dbg_data;
            if (!dbg_on && !m_halt) begin
                word = m_mem[(m_pc / 4) % MW];
                stop = 0;
                if (flush) begin
                    m_instr = 0;
                    m_iaddr = m_pc + 4;
                end else if (ifid_write) begin
                    m_iaddr = m_pc + 4;
                    if (word == HALT) begin
                        m_instr = 0;
                        m_halt  = 1;
                        stop    = 1;
                    end else begin
                        m_instr = word;
                        m_count = m_count + 1;
                    end
                end
                if (!stop) begin
                    if (pc_sel) m_pc = pc_branch;
                    else if (pc_write) m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc",    o_pc,            m_pc);
        check("instr", o_instr,         m_instr);
        check("iaddr", o_iaddr,         m_iaddr);
        check("count", o_count,         m_count);
        check("halt",  32'(o_halt),     32'(m_halt));
    endtask

    task automatic run_defaults();
        rst = 0; pc_write = 1; ifid_write = 1; pc_sel = 0; pc_branch = 0;
        flush = 0; dbg_on = 0; dbg_we = 0; dbg_addr = '0; dbg_data = 0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        run_defaults();
        dbg_on = 1; dbg_we = 1; dbg_addr = AW'(a); dbg_data = d;
        tick();
        run_defaults();
    endtask

    task automatic do_reset();
        run_defaults();
        rst = 1;
        tick();
        run_defaults();
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_pc = 0; m_instr = 0; m_iaddr = 0; m_count = 0; m_halt = 0;
        for (int i = 0; i < int'(MW); i++) m_mem[i] = 'x;

        // Reset state
        do_reset();
        check("rst_pc", o_pc, 32'h0);
        check("rst_halt", 32'(o_halt), 32'h0);

        // Program A,B,C,HALT then straight-line code
        for (int i = 0; i < int'(MW); i++) load(i, (i == 3) ? HALT : prog(i));

        // Run into the halt word
        for (int i = 0; i < 4; i++) tick();
        check("halt_set",   32'(o_halt), 32'h1);
        check("halt_pc",    o_pc,        32'd12);
        check("halt_count", o_count,     32'd3);
        check("halt_iaddr", o_iaddr,     32'd16);
        check("halt_instr", o_instr,     32'h0);
        // Held while halted, even with a taken branch
        pc_sel = 1; pc_branch = 32'h80;
        tick(); tick();
        check("halt_hold_pc", o_pc, 32'd12);
        run_defaults();

        // Reset while halted with a pending load: load is dropped
        rst = 1; dbg_on = 1; dbg_we = 1; dbg_addr = '0; dbg_data = 32'hDEAD_BEEF;
        tick();
        run_defaults();
        check("rst2_instr", o_instr, 32'h0);
        check("rst2_halt",  32'(o_halt), 32'h0);
        load(3, prog(3));
        tick();
        check("restart_instr", o_instr, prog(0));

        // Load-use stall at PC=8
        tick();
        check("pre_stall_pc", o_pc, 32'd8);
        pc_write = 0; ifid_write = 0;
        tick(); tick();
        check("stall_pc",    o_pc,    32'd8);
        check("stall_instr", o_instr, prog(1));
        check("stall_count", o_count, 32'd2);
        run_defaults();
        tick();
        check("resume_instr", o_instr, prog(2));
        check("resume_pc",    o_pc,    32'd12);

        // Taken branch under stall with flush at PC=4
        do_reset();
        tick();
        pc_sel = 1; pc_branch = 32'h40; flush = 1; pc_write = 0;
        tick();
        check("br_pc",    o_pc,    32'h40);
        check("br_instr", o_instr, 32'h0);
        check("br_count", o_count, 32'd1);
        run_defaults();

        // Wrap of the memory index past the last word
        pc_sel = 1; pc_branch = 32'(4 * MW - 4); flush = 1;
        tick();
        run_defaults();
        tick();
        check("wrap_last", o_instr, prog(int'(MW) - 1));
        tick();
        check("wrap_instr", o_instr, prog(0));
        check("wrap_iaddr", o_iaddr, 32'(4 * MW + 4));

        // Halt word fetched on a flushed (wrong) path
        load(5, HALT);
        pc_sel = 1; pc_branch = 32'd20; flush = 1;
        tick();
        run_defaults();
        flush = 1;
        tick();
        check("flush_halt", 32'(o_halt), 32'h0);
        check("flush_instr", o_instr, 32'h0);
        run_defaults();

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            dbg_on     = ($urandom_range(0, 4) == 0);
            dbg_we     = ($urandom_range(0, 1) == 0);
            dbg_addr   = AW'($urandom_range(0, MW - 1));
            dbg_data   = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
            flush      = ($urandom_range(0, 5) == 0);
            pc_sel     = ($urandom_range(0, 4) == 0);
            pc_branch  = $urandom & 32'hFFFF_FFFC;
            pc_write   = ($urandom_range(0, 3) != 0);
            ifid_write = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
